// File: rtl/pipe_id_exe.sv
// ID/EXE pipeline register with RAW forwarding or interlock.
// Define PIPE_ID_EXE_FWD_EN to build with forwarding muxes.
module pipe_id_exe (
  input  logic        clock,
  input  logic        resetn,
  input  logic        id_valid,
  input  logic [31:0] id_rd1,
  input  logic [31:0] id_rd2,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rn,
  input  logic        id_wreg,
  input  logic [31:0] id_shamt32,
  input  logic        id_shift,
  input  logic [3:0]  id_aluc,
  input  logic        flush,
  input  logic [31:0] exe_alud,
  input  logic [31:0] mem_wdata,
  input  logic [4:0]  mem_rn,
  input  logic        mem_wreg,
  output logic        e_valid,
  output logic        e_wreg,
  output logic        e_shift,
  output logic [31:0] e_rd1,
  output logic [31:0] e_rd2,
  output logic [31:0] e_shamt32,
  output logic [3:0]  e_aluc,
  output logic [4:0]  e_rn,
  output logic        stall,
  output logic [15:0] stall_cnt
);

  typedef struct packed {
    logic        valid;
    logic        wreg;
    logic        shift;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] shamt32;
    logic [3:0]  aluc;
    logic [4:0]  rn;
  } ex_t;

  ex_t         e_q;
  ex_t         e_d;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        e_src;
  logic        m_src;
  logic        hite_a;
  logic        hite_b;
  logic        hitm_a;
  logic        hitm_b;
  logic        dep_a;
  logic        dep_b;
  logic        bubble;

  assign e_src  = e_q.valid & e_q.wreg & (e_q.rn != 5'd0);
  assign m_src  = mem_wreg & (mem_rn != 5'd0);
  assign hite_a = e_src & (e_q.rn == id_rs);
  assign hite_b = e_src & (e_q.rn == id_rt);
  assign hitm_a = m_src & (mem_rn == id_rs);
  assign hitm_b = m_src & (mem_rn == id_rt);
  assign dep_a  = ~id_shift & (hite_a | hitm_a);
  assign dep_b  = hite_b | hitm_b;

`ifdef PIPE_ID_EXE_FWD_EN
  logic unused_dep;
  assign unused_dep = dep_a | dep_b;
  assign stall = 1'b0;

  // Operand muxes: EXE result beats MEM result beats register file.
  always_comb begin
    opa = id_rd1;
    opb = id_rd2;
    if (~id_shift & hite_a)      opa = exe_alud;
    else if (~id_shift & hitm_a) opa = mem_wdata;
    if (hite_b)      opb = exe_alud;
    else if (hitm_b) opb = mem_wdata;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{exe_alud, mem_wdata};
  assign opa   = id_rd1;
  assign opb   = id_rd2;
  assign stall = resetn & id_valid & ~flush
               & (dep_a | dep_b);
`endif

  assign bubble = flush | stall;

  // Next pipeline-register contents: a bubble zeroes everything.
  always_comb begin
    e_d = '0;
    if (!bubble) begin
      e_d.valid   = id_valid;
      e_d.wreg    = id_wreg;
      e_d.shift   = id_shift;
      e_d.rd1     = opa;
      e_d.rd2     = opb;
      e_d.shamt32 = id_shamt32;
      e_d.aluc    = id_aluc;
      e_d.rn      = id_rn;
    end
  end

  // Pipeline register and saturating interlock-bubble counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      e_q       <= '0;
      stall_cnt <= 16'd0;
    end else begin
      e_q <= e_d;
      if (stall && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign e_valid   = e_q.valid;
  assign e_wreg    = e_q.wreg;
  assign e_shift   = e_q.shift;
  assign e_rd1     = e_q.rd1;
  assign e_rd2     = e_q.rd2;
  assign e_shamt32 = e_q.shamt32;
  assign e_aluc    = e_q.aluc;
  assign e_rn      = e_q.rn;

endmodule
